rv_issue_sequencer: RTL and testbench

RV_ISSUE_SEQUENCER -- requirements
Module: rv_issue_sequencer

---
 rtl/rv_issue_sequencer_pkg.sv | 22 ++
 rtl/rv_rtype_decode.sv | 36 +++
 rtl/rv_issue_sequencer.sv | 132 +++++++++++++
 tb/tb_rv_issue_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_issue_sequencer_pkg.sv
// Shared constants and types for the R-type issue sequencer slice.
package rv_issue_sequencer_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_WB
  } seq_state_e;

endpackage

// File: rtl/rv_rtype_decode.sv
// Combinational RV32 R-type decoder: funct7/funct3/opcode -> ALU control.
module rv_rtype_decode
  import rv_issue_sequencer_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        is_mul,
  output logic        illegal
);

  // Table lookup; anything outside the table is rejected with alu_op forced to 0.
  always_comb begin
    alu_op  = '0;
    is_mul  = 1'b0;
    illegal = 1'b0;
    if (instr[6:0] != OP_RTYPE) begin
      illegal = 1'b1;
    end else begin
      case ({instr[31:25], instr[14:12]})
        {7'd0,  3'd0}: alu_op = ALU_ADD;
        {7'd32, 3'd0}: alu_op = ALU_SUB;
        {7'd0,  3'd6}: alu_op = ALU_OR;
        {7'd0,  3'd7}: alu_op = ALU_AND;
        {7'd0,  3'd1}: alu_op = ALU_SLL;
        {7'd0,  3'd5}: alu_op = ALU_SRL;
        {7'd0,  3'd4}: alu_op = ALU_XOR;
        {7'd0,  3'd2}: begin
          alu_op = ALU_MUL;
          is_mul = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/rv_issue_sequencer.sv
// Issue sequencer: accepts one R-type word, decodes it, optionally waits for
// the multi-cycle multiplier, and strobes the register-file write.
module rv_issue_sequencer
  import rv_issue_sequencer_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        busy,
  output logic        illegal,
  output logic        timeout
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MUL_TIMEOUT);

  seq_state_e  state_q, state_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic        is_mul_q, is_mul_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        alu_start_q, alu_start_d;
  logic        rf_we_q, rf_we_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  dec_alu_op;
  logic        dec_is_mul;
  logic        dec_illegal;

  // The word is decoded as it is latched, so alu_op, alu_start and illegal
  // are already registered during the DECODE cycle.
  rv_rtype_decode u_decode (
    .instr   (instr),
    .alu_op  (dec_alu_op),
    .is_mul  (dec_is_mul),
    .illegal (dec_illegal)
  );

  // Next-state and registered-output computation for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    rf_waddr_d  = rf_waddr_q;
    is_mul_d    = is_mul_q;
    cnt_d       = cnt_q;
    alu_start_d = 1'b0;
    rf_we_d     = 1'b0;
    illegal_d   = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d     = ST_DECODE;
          alu_op_d    = dec_alu_op;
          rf_waddr_d  = dec_illegal ? 5'd0 : instr[11:7];
          is_mul_d    = dec_is_mul;
          alu_start_d = dec_is_mul;
          illegal_d   = dec_illegal;
        end
      end
      ST_DECODE: begin
        if (illegal_q) begin
          state_d = ST_IDLE;
        end else if (is_mul_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_WB;
          rf_we_d = (rf_waddr_q != 5'd0);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (alu_done) begin
          state_d = ST_WB;
          rf_we_d = (rf_waddr_q != 5'd0);
        end else if (cnt_d == WAIT_LIMIT) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      alu_op_q    <= '0;
      rf_waddr_q  <= '0;
      is_mul_q    <= 1'b0;
      cnt_q       <= '0;
      alu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      rf_waddr_q  <= rf_waddr_d;
      is_mul_q    <= is_mul_d;
      cnt_q       <= cnt_d;
      alu_start_q <= alu_start_d;
      rf_we_q     <= rf_we_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign alu_op      = alu_op_q;
  assign rf_waddr    = rf_waddr_q;
  assign alu_start   = alu_start_q;
  assign rf_we       = rf_we_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rv_issue_sequencer.sv
// Directed bench for rv_issue_sequencer with hand-computed expectations.
module tb_rv_issue_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        busy;
  logic        illegal;
  logic        timeout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  rv_issue_sequencer #(.MUL_TIMEOUT(15)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .busy        (busy),
    .illegal     (illegal),
    .timeout     (timeout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd3, 5'd1, f3, rd, opc};
  endfunction

  // Offers one word in the current cycle (N); returns at cycle N+1.
  task automatic issue(input logic [31:0] w, input string tag);
    check_eq({tag, " ready@N"}, 32'(instr_ready), 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  logic [31:0] ops [6];
  logic [3:0]  exp_ops [6];
  logic        seen_we;

  initial begin
    ops[0] = rtype(7'd0, 3'd0, 5'd11, 7'b0110011); exp_ops[0] = 4'b0010;
    ops[1] = rtype(7'd0, 3'd6, 5'd12, 7'b0110011); exp_ops[1] = 4'b0001;
    ops[2] = rtype(7'd0, 3'd7, 5'd13, 7'b0110011); exp_ops[2] = 4'b0000;
    ops[3] = rtype(7'd0, 3'd1, 5'd14, 7'b0110011); exp_ops[3] = 4'b0011;
    ops[4] = rtype(7'd0, 3'd5, 5'd15, 7'b0110011); exp_ops[4] = 4'b0101;
    ops[5] = rtype(7'd0, 3'd4, 5'd31, 7'b0110011); exp_ops[5] = 4'b0111;

    // Reset with a valid word offered: must not be accepted.
    wb_rst_i    = 1'b1;
    instr       = 32'h40208133;
    instr_valid = 1'b1;
    tick();
    tick();
    instr_valid = 1'b0;
    wb_rst_i    = 1'b0;
    check_eq("rst ready", 32'(instr_ready), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst alu_op", 32'(alu_op), 32'd0);
    check_eq("rst waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst pulses", {28'd0, alu_start, rf_we, illegal, timeout}, 32'd0);
    tick();
    check_eq("rst no accept", 32'(busy), 32'd0);

    // alu_done in IDLE is ignored.
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check_eq("done idle busy", 32'(busy), 32'd0);
    check_eq("done idle we", 32'(rf_we), 32'd0);

    // SUB x2.
    issue(32'h40208133, "sub");
    check_eq("sub op N+1", 32'(alu_op), 32'd4);
    check_eq("sub we N+1", 32'(rf_we), 32'd0);
    check_eq("sub ready N+1", 32'(instr_ready), 32'd0);
    check_eq("sub busy N+1", 32'(busy), 32'd1);
    tick();
    check_eq("sub we N+2", 32'(rf_we), 32'd1);
    check_eq("sub waddr N+2", 32'(rf_waddr), 32'd2);
    check_eq("sub op N+2", 32'(alu_op), 32'd4);
    check_eq("sub ready N+2", 32'(instr_ready), 32'd0);
    tick();
    check_eq("sub we N+3", 32'(rf_we), 32'd0);
    check_eq("sub ready N+3", 32'(instr_ready), 32'd1);

    // Remaining single-cycle ops.
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], "op");
      check_eq("op alu_op", 32'(alu_op), 32'(exp_ops[i]));
      check_eq("op start", 32'(alu_start), 32'd0);
      tick();
      check_eq("op we", 32'(rf_we), 32'd1);
      check_eq("op waddr", 32'(rf_waddr), 32'(ops[i][11:7]));
      tick();
    end

    // MUL x5, alu_done 4 cycles after alu_start.
    issue(rtype(7'd0, 3'd2, 5'd5, 7'b0110011), "mul");
    check_eq("mul start N+1", 32'(alu_start), 32'd1);
    check_eq("mul op N+1", 32'(alu_op), 32'd6);
    tick();
    check_eq("mul start N+2", 32'(alu_start), 32'd0);
    tick();
    tick();
    tick();
    alu_done = 1'b1;
    check_eq("mul we N+5", 32'(rf_we), 32'd0);
    tick();
    alu_done = 1'b0;
    check_eq("mul we N+6", 32'(rf_we), 32'd1);
    check_eq("mul waddr N+6", 32'(rf_waddr), 32'd5);
    check_eq("mul op N+6", 32'(alu_op), 32'd6);
    tick();
    check_eq("mul we N+7", 32'(rf_we), 32'd0);
    check_eq("mul ready N+7", 32'(instr_ready), 32'd1);

    // MUL timeout; alu_done during DECODE must be ignored.
    issue(rtype(7'd0, 3'd2, 5'd7, 7'b0110011), "mto");
    alu_done = 1'b1;
    seen_we  = 1'b0;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      seen_we = seen_we | rf_we;
      check_eq("mto no early timeout", 32'(timeout), 32'd0);
      tick();
    end
    check_eq("mto busy N+16", 32'(busy), 32'd1);
    tick();
    seen_we = seen_we | rf_we;
    check_eq("mto timeout N+17", 32'(timeout), 32'd1);
    check_eq("mto ready N+17", 32'(instr_ready), 32'd1);
    check_eq("mto no we", 32'(seen_we), 32'd0);
    tick();
    check_eq("mto pulse once", 32'(timeout), 32'd0);

    // alu_done exactly on the limit cycle wins over timeout.
    issue(rtype(7'd0, 3'd2, 5'd9, 7'b0110011), "mlim");
    repeat (15) tick();
    check_eq("mlim busy N+16", 32'(busy), 32'd1);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check_eq("mlim we", 32'(rf_we), 32'd1);
    check_eq("mlim waddr", 32'(rf_waddr), 32'd9);
    check_eq("mlim no timeout", 32'(timeout), 32'd0);
    tick();
    check_eq("mlim no late timeout", 32'(timeout), 32'd0);

    // Illegal opcode (OP-IMM).
    issue(rtype(7'd0, 3'd0, 5'd3, 7'b0010011), "ill_opc");
    check_eq("ill_opc pulse", 32'(illegal), 32'd1);
    check_eq("ill_opc op", 32'(alu_op), 32'd0);
    check_eq("ill_opc waddr", 32'(rf_waddr), 32'd0);
    tick();
    check_eq("ill_opc clear", 32'(illegal), 32'd0);
    check_eq("ill_opc we", 32'(rf_we), 32'd0);
    check_eq("ill_opc ready", 32'(instr_ready), 32'd1);

    // funct3 = 3.
    issue(rtype(7'd0, 3'd3, 5'd4, 7'b0110011), "ill_f3");
    check_eq("ill_f3 pulse", 32'(illegal), 32'd1);
    tick();
    check_eq("ill_f3 we", 32'(rf_we), 32'd0);
    check_eq("ill_f3 ready", 32'(instr_ready), 32'd1);

    // funct7 = 32 with funct3 = 6 is not in the table.
    issue(rtype(7'd32, 3'd6, 5'd8, 7'b0110011), "ill_f7");
    check_eq("ill_f7 pulse", 32'(illegal), 32'd1);
    tick();

    // ADD to x0: full busy sequence, no write.
    issue(rtype(7'd0, 3'd0, 5'd0, 7'b0110011), "add0");
    check_eq("add0 busy N+1", 32'(busy), 32'd1);
    check_eq("add0 op", 32'(alu_op), 32'd2);
    tick();
    check_eq("add0 busy N+2", 32'(busy), 32'd1);
    check_eq("add0 we", 32'(rf_we), 32'd0);
    tick();
    check_eq("add0 ready N+3", 32'(instr_ready), 32'd1);

    // Reset while in WAIT, with alu_done asserted.
    issue(rtype(7'd0, 3'd2, 5'd6, 7'b0110011), "mrst");
    tick();
    tick();
    check_eq("mrst in wait", 32'(busy), 32'd1);
    wb_rst_i = 1'b1;
    alu_done = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    alu_done = 1'b0;
    check_eq("mrst ready", 32'(instr_ready), 32'd1);
    check_eq("mrst pulses", {28'd0, alu_start, rf_we, illegal, timeout}, 32'd0);
    check_eq("mrst op", 32'(alu_op), 32'd0);
    check_eq("mrst waddr", 32'(rf_waddr), 32'd0);
    tick();
    check_eq("mrst quiet", {28'd0, busy, rf_we, illegal, timeout}, 32'd0);

    issue(32'h40208133, "post");
    check_eq("post op", 32'(alu_op), 32'd4);
    tick();
    check_eq("post we", 32'(rf_we), 32'd1);
    check_eq("post waddr", 32'(rf_waddr), 32'd2);
    tick();
    check_eq("post ready", 32'(instr_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
